pipelined_borrow_lookahead_subtractor: RTL and testbench
========================================================

Name: pipelined_borrow_lookahead_subtractor

Overview:
- Two-stage pipelined, registered subtractor computing DIFF = A − B − BIN.
- Uses 2-level borrow-lookahead: 4-bit blocks produce group borrow-generate/propagate; a top level resolves the inter-block borrows.
- Complements the adder's block carry-lookahead path in the ALU datapath.
- Valid/ready handshakes on both sides, so it sits directly between operand registers and the writeback stage.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4, legal range 8–32.
- BLOCK, 4, bits per lookahead block; fixed at 4, not overridable in practice.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- diff  output  WIDTH  A − B − BIN mod 2^WIDTH.
- bout  output  1  borrow out; 1 iff unsigned A < B + BIN.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  diff == 0.

Behaviour:
- Reset (async, rst=1): s1_valid=0, out_valid=0, diff=0, bout=0, ovf=0, zero=0. in_ready=1 from the first clock after rst deasserts. Any in-flight data is discarded.
- Per-bit terms:
  - borrow-generate g_i = ~a_i & b_i
  - borrow-propagate p_i = ~(a_i ^ b_i)
- Per block:
  - G* = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - P* = p3·p2·p1·p0
  - internal borrows follow the same form as carries, with bin as the block-0 input.
- Stage 1: on a transfer (in_valid & in_ready), register a, b, bin, and all per-block G*/P*.
- Stage 2:
  - Compute block borrow-ins B_{k+1} = G*_k | P*_k·B_k, with B_0 = bin.
  - diff_i = a_i ^ b_i ^ borrow_i.
  - bout = B_{WIDTH/4}.
  - ovf = (a_msb ≠ b_msb) & (diff_msb ≠ a_msb).
  - zero = ~|diff.
  - All of these are registered into the output.
- Latency: exactly 2 cycles from the accepting edge to out_valid=1 with no backpressure. Throughput is 1 operation per cycle.
- Flow control:
  - s2_advance = ~out_valid | out_ready.
  - s1_advance = s1_valid & s2_advance.
  - in_ready = ~s1_valid | s2_advance.
  - in_ready is combinational from out_ready; no other combinational in→out paths.
- Holding: while out_valid & ~out_ready, diff/bout/ovf/zero are stable and out_valid stays 1.
- Capacity: maximum 2 operations in flight. With a full pipe and out_ready=0, in_ready=0.
- Simultaneous events: an input accept, stage-1 advance and output consume in the same cycle all take effect. Ordering is strictly FIFO.
- Idle: out_valid drops to 0 the cycle after the last result is consumed with no stage-1 data pending.
- Operand width: no sign extension internally.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: when ovf=1, diff is clamped to the signed limit.
  - 0x7FFF (WIDTH-scaled) if a_msb=0.
  - 0x8000 (WIDTH-scaled) if a_msb=1.
  - ovf still reports 1. zero is computed on the clamped value.
- Undefined: diff always wraps modulo 2^WIDTH. No saturation logic is present.

Decomposition:
- Package sub_pkg:
  - BLOCK_W=4
  - function nblocks(width)
  - localparam for signed max/min derivation
  - struct type for the stage-1 payload (a, b, bin, G*[], P*[])
- Sub-module block_borrow_lookahead_unit:
  - 4-bit combinational; inputs g[3:0], p[3:0], bi.
  - Outputs G*, P*, internal borrows[3:1].
  - Instantiated WIDTH/4 times in stage 1, and reused in stage 2 as the top-level resolver when WIDTH/4 ≤ 4.

Test Plan:
- 0x0005−0x0003, bin=0 → diff=0x0002, bout=0, ovf=0, zero=0; out_valid exactly 2 cycles after accept.
- 0x0000−0x0001 → diff=0xFFFF, bout=1, ovf=0 (checks a full borrow ripple across all 4 blocks).
- 0x1000−0x0FFF, bin=1 → diff=0x0000, bout=0, zero=1 (checks group-propagate chain and bin).
- 0x8000−0x0001 → diff=0x7FFF, ovf=1, bout=0; with SUB_SATURATE_EN → diff=0x8000, ovf=1.
- Backpressure: out_ready=0, three back-to-back in_valid pulses → only 2 accepted, in_ready=0 on the 3rd; then raising out_ready drains the results in order with diff stable while held.
- rst asserted with 2 ops in flight → out_valid=0 and outputs=0 immediately (async); next op after release has 2-cycle latency and a correct result.

Source files
------------

// File: rtl/pipelined_borrow_lookahead_subtractor_pkg.sv
// sub_pkg: shared constants, block group terms and saturation helper for the borrow-lookahead subtractor
package sub_pkg;
   localparam int BLOCK_W = 4;
   localparam int MIN_W = 8;
   localparam int MAX_W = 32;
   typedef struct packed {
      logic gg;
      logic pg;
   } grp_t;
   function automatic int nblocks(input int width);
      return width / BLOCK_W;
   endfunction
   // signed limit for a given width: most negative when neg, else most positive
   function automatic logic [MAX_W-1:0] sat_limit(input int width, input logic neg);
      logic [MAX_W-1:0] m;
      m = MAX_W'(1) << (width - 1);
      return neg ? m : m - 1'b1;
   endfunction
endpackage

// File: rtl/pipelined_borrow_lookahead_subtractor_block_borrow_lookahead_unit.sv
// block_borrow_lookahead_unit: 4-bit borrow-lookahead cell producing group G*/P* and internal borrows
module block_borrow_lookahead_unit (
   input  logic [3:0] g,
   input  logic [3:0] p,
   input  logic       bi,
   output logic       gg,
   output logic       pg,
   output logic [3:1] bo
);
   assign bo[1] = g[0] | (p[0] & bi);
   assign bo[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
   assign bo[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
   assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign pg = &p;
endmodule

// File: rtl/pipelined_borrow_lookahead_subtractor.sv
// pipelined_borrow_lookahead_subtractor: two-stage valid/ready subtractor, diff = a - b - bin.
// Define SUB_SATURATE_EN to clamp diff to the signed limit on overflow.
module pipelined_borrow_lookahead_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int BLOCK = BLOCK_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);
   localparam int NB = nblocks(WIDTH);
   if (BLOCK != BLOCK_W || WIDTH % BLOCK_W != 0 || WIDTH < MIN_W || WIDTH > MAX_W) begin : g_bad_cfg
      $error("unsupported WIDTH/BLOCK");
   end
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             bin;
      grp_t [NB-1:0]    grp;
   } s1_t;
   s1_t s1;
   logic s1_valid, s2_advance, s1_advance, accept;
   logic [WIDTH-1:0] g1, p1, g2, p2, brw, raw, diff_n;
   logic [NB-1:0] gs, ps;
   logic [NB:0] bk;
   logic ovf_n;
   grp_t [NB-1:0] grp1;
   assign s2_advance = ~out_valid | out_ready;
   assign s1_advance = s1_valid & s2_advance;
   assign in_ready = ~s1_valid | s2_advance;
   assign accept = in_valid & in_ready;
   assign g1 = ~a & b;
   assign p1 = ~(a ^ b);
   assign g2 = ~s1.a & s1.b;
   assign p2 = ~(s1.a ^ s1.b);
   for (genvar k = 0; k < NB; k++) begin : g_blk
      logic [3:1] unused_bo1, bo2;
      logic unused_gg2, unused_pg2;
      block_borrow_lookahead_unit u_s1 (
         .g(g1[4*k +: 4]), .p(p1[4*k +: 4]), .bi(1'b0),
         .gg(grp1[k].gg), .pg(grp1[k].pg), .bo(unused_bo1)
      );
      block_borrow_lookahead_unit u_s2 (
         .g(g2[4*k +: 4]), .p(p2[4*k +: 4]), .bi(bk[k]),
         .gg(unused_gg2), .pg(unused_pg2), .bo(bo2)
      );
      assign brw[4*k +: 4] = {bo2, bk[k]};
      assign gs[k] = s1.grp[k].gg;
      assign ps[k] = s1.grp[k].pg;
   end
   // inter-block borrows: one lookahead cell covers up to four blocks, wider words ripple the group terms
   if (NB <= 4) begin : g_top_cla
      logic tgg, tpg;
      logic [3:1] tb;
      block_borrow_lookahead_unit u_top (
         .g(4'(gs)), .p(4'(ps)), .bi(s1.bin), .gg(tgg), .pg(tpg), .bo(tb)
      );
      assign bk = (NB+1)'({tgg | (tpg & s1.bin), tb, s1.bin});
   end else begin : g_top_ripple
      always_comb begin
         logic c;
         c = s1.bin;
         bk = '0;
         bk[0] = c;
         for (int i = 0; i < NB; i++) begin
            c = gs[i] | (ps[i] & c);
            bk[i+1] = c;
         end
      end
   end
   assign raw = s1.a ^ s1.b ^ brw;
   assign ovf_n = (s1.a[WIDTH-1] != s1.b[WIDTH-1]) & (raw[WIDTH-1] != s1.a[WIDTH-1]);
`ifdef SUB_SATURATE_EN
   assign diff_n = ovf_n ? WIDTH'(sat_limit(WIDTH, s1.a[WIDTH-1])) : raw;
`else
   assign diff_n = raw;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s1_valid <= 1'b0;
         out_valid <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
         ovf <= 1'b0;
         zero <= 1'b0;
      end else begin
         if (accept) begin
            s1.a <= a;
            s1.b <= b;
            s1.bin <= bin;
            s1.grp <= grp1;
         end
         s1_valid <= accept | (s1_valid & ~s1_advance);
         if (s2_advance) out_valid <= s1_valid;
         if (s1_advance) begin
            diff <= diff_n;
            bout <= bk[NB];
            ovf <= ovf_n;
            zero <= ~|diff_n;
         end
      end
   end
endmodule

// File: tb/tb_pipelined_borrow_lookahead_subtractor.sv
// tb_pipelined_borrow_lookahead_subtractor: directed vectors for the pipelined borrow-lookahead subtractor
module tb_pipelined_borrow_lookahead_subtractor;
   logic clk = 0, rst = 0, in_valid = 0, bin = 0, out_ready = 1;
   logic in_ready, out_valid, bout, ovf, zero;
   logic [15:0] a = '0, b = '0, diff;
   int n_vec = 0, n_err = 0;
`ifdef SUB_SATURATE_EN
   localparam logic [15:0] E_NEG_OVF = 16'h8000, E_POS_OVF = 16'h7FFF;
`else
   localparam logic [15:0] E_NEG_OVF = 16'h7FFF, E_POS_OVF = 16'h8000;
`endif
   localparam logic [15:0] SA [3] = '{16'h0003, 16'h0009, 16'h0100};
   localparam logic [15:0] SB [3] = '{16'h0001, 16'h0004, 16'h0001};
   localparam logic [15:0] SE [3] = '{16'h0002, 16'h0005, 16'h00FF};
   always #5 clk = ~clk;
   pipelined_borrow_lookahead_subtractor #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic bi,
                         input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
      a = av;
      b = bv;
      bin = bi;
      in_valid = 1;
      out_ready = 1;
      check({tag, ".in_ready"}, in_ready, 1);
      tick;
      in_valid = 0;
      check({tag, ".lat1"}, out_valid, 0);
      tick;
      check({tag, ".lat2"}, out_valid, 1);
      check({tag, ".diff"}, diff, ed);
      check({tag, ".bout"}, bout, eb);
      check({tag, ".ovf"}, ovf, eo);
      check({tag, ".zero"}, zero, ez);
      tick;
      check({tag, ".idle"}, out_valid, 0);
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      #2 rst = 1;
      #1;
      check("rst.out_valid", out_valid, 0);
      check("rst.diff", diff, 0);
      check("rst.flags", {bout, ovf, zero}, 0);
      repeat (2) tick;
      rst = 0;
      check("rst.in_ready", in_ready, 1);
      run_op("v5m3", 16'h0005, 16'h0003, 0, 16'h0002, 0, 0, 0);
      run_op("v0m1", 16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0);
      run_op("vprop", 16'h1000, 16'h0FFF, 1, 16'h0000, 0, 0, 1);
      run_op("vnegovf", 16'h8000, 16'h0001, 0, E_NEG_OVF, 0, 1, 0);
      run_op("vposovf", 16'h7FFF, 16'hFFFF, 0, E_POS_OVF, 1, 1, 0);
      run_op("vallbin", 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         a = SA[i];
         b = SB[i];
         bin = 0;
         in_valid = 1;
         tick;
         if (i > 0) check($sformatf("stream.diff%0d", i - 1), diff, SE[i-1]);
      end
      in_valid = 0;
      tick;
      check("stream.diff2", diff, SE[2]);
      check("stream.valid", out_valid, 1);
      tick;
      check("stream.idle", out_valid, 0);
      out_ready = 0;
      a = 16'h0010;
      b = 16'h0001;
      in_valid = 1;
      tick;
      check("bp.in_ready2", in_ready, 1);
      a = 16'h0020;
      b = 16'h0002;
      tick;
      a = 16'h0030;
      b = 16'h0003;
      check("bp.in_ready3", in_ready, 0);
      check("bp.valid", out_valid, 1);
      check("bp.diff0", diff, 16'h000F);
      tick;
      check("bp.hold_diff", diff, 16'h000F);
      check("bp.hold_ready", in_ready, 0);
      check("bp.hold_valid", out_valid, 1);
      in_valid = 0;
      out_ready = 1;
      tick;
      check("bp.drain_diff", diff, 16'h001E);
      check("bp.drain_valid", out_valid, 1);
      tick;
      check("bp.third_dropped", out_valid, 0);
      out_ready = 0;
      a = 16'h0040;
      b = 16'h0001;
      in_valid = 1;
      tick;
      a = 16'h0050;
      tick;
      in_valid = 0;
      check("rf.pre_valid", out_valid, 1);
      check("rf.pre_diff", diff, 16'h003F);
      rst = 1;
      #1;
      check("rf.out_valid", out_valid, 0);
      check("rf.diff", diff, 0);
      check("rf.in_ready", in_ready, 1);
      tick;
      rst = 0;
      run_op("post", 16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
